// File: rtl/dmc_pkg.sv
// Shared types and constants for the differential-Manchester line encoder.
// Holds the FSM state encoding, preamble default, half-bit floor and scrambler LFSR.
package dmc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_DATA = 2'd2
  } dmc_state_e;

  localparam int DMC_PRE_UNITS = 3;
  localparam int HP_MIN        = 2;

  // Additive scrambler x^7 + x^6 + 1: key is the feedback bit of the current state.
  localparam int                LFSR_W    = 7;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 7'h60;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 7'h7F;

  function automatic logic lfsr_key(input logic [LFSR_W-1:0] s);
    return ^(s & LFSR_TAPS);
  endfunction

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], lfsr_key(s)};
  endfunction

endpackage

// File: rtl/dmc_scrambler.sv
// Additive LFSR scrambler for the line encoder; used only with DMC_ENC_SCRAMBLE_EN.
// load reseeds so the beat carrying it is scrambled with the seed state itself.
module dmc_scrambler
  import dmc_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic advance,
  input  logic din,
  output logic dout
);

  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] cur;

  assign cur  = load ? LFSR_SEED : lfsr;
  assign dout = din ^ lfsr_key(cur);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      lfsr <= LFSR_SEED;
    else if (advance)
      lfsr <= lfsr_step(cur);
  end

endmodule

// File: rtl/dmc_encode.sv
// Differential-Manchester (biphase-mark) line encoder with sync preamble of two 1.5-bit runs.
// Optional build macro DMC_ENC_SCRAMBLE_EN inserts the additive LFSR scrambler ahead of encoding.
module dmc_encode
  import dmc_pkg::*;
#(
  parameter int HP_W      = 8,
  parameter int PRE_UNITS = DMC_PRE_UNITS
) (
  input  logic            clk_i,
  input  logic            reset,
  input  logic            enable,
  input  logic [HP_W-1:0] HALF_PERIOD,
  input  logic            s_valid,
  input  logic            s_data,
  input  logic            s_sync,
  output logic            s_ready,
  output logic            line_o,
  output logic            line_oe,
  output logic            busy_o,
  output logic            underrun_o
);

  localparam logic [HP_W-1:0] ONE      = HP_W'(1);
  localparam logic [1:0]      RUN_LOAD = 2'(PRE_UNITS - 1);

  dmc_state_e      state;
  logic [HP_W-1:0] hp;
  logic [HP_W-1:0] cnt;
  logic [1:0]      run;
  logic            second_run;
  logic            half;
  logic            bit_q;

  logic            accept;
  logic            enc_bit;
  logic [HP_W-1:0] hp_in;

  assign accept = s_valid && s_ready;
  assign hp_in  = (HALF_PERIOD < HP_W'(HP_MIN)) ? HP_W'(HP_MIN) : HALF_PERIOD;

`ifdef DMC_ENC_SCRAMBLE_EN
  dmc_scrambler u_scrambler (
    .clk     (clk_i),
    .rst     (reset),
    .load    (accept && s_sync),
    .advance (accept),
    .din     (s_data),
    .dout    (enc_bit)
  );
`else
  assign enc_bit = s_data;
`endif

  // s_ready is only ever high in IDLE or the last cycle of a bit, so an accepted
  // beat always starts a fresh bit or preamble regardless of the current state.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      hp         <= '0;
      cnt        <= '0;
      run        <= '0;
      second_run <= 1'b0;
      half       <= 1'b0;
      bit_q      <= 1'b0;
      s_ready    <= 1'b0;
      line_o     <= 1'b0;
      line_oe    <= 1'b0;
      busy_o     <= 1'b0;
      underrun_o <= 1'b0;
    end else begin
      underrun_o <= 1'b0;
      if (accept) begin
        hp         <= hp_in;
        cnt        <= hp_in - ONE;
        bit_q      <= enc_bit;
        half       <= 1'b0;
        run        <= RUN_LOAD;
        second_run <= 1'b0;
        line_o     <= ~line_o;
        line_oe    <= 1'b1;
        busy_o     <= 1'b1;
        s_ready    <= 1'b0;
        state      <= s_sync ? ST_PRE : ST_DATA;
      end else begin
        case (state)
          ST_IDLE: s_ready <= enable;
          ST_PRE: begin
            if (cnt != '0) begin
              cnt <= cnt - ONE;
            end else if (run != 2'd0) begin
              run <= run - 2'd1;
              cnt <= hp - ONE;
            end else begin
              line_o <= ~line_o;
              cnt    <= hp - ONE;
              if (!second_run) begin
                second_run <= 1'b1;
                run        <= RUN_LOAD;
              end else begin
                half  <= 1'b0;
                state <= ST_DATA;
              end
            end
          end
          ST_DATA: begin
            if (cnt != '0) begin
              cnt <= cnt - ONE;
              if (half && cnt == ONE)
                s_ready <= enable;
            end else if (!half) begin
              half <= 1'b1;
              cnt  <= hp - ONE;
              if (bit_q)
                line_o <= ~line_o;
            end else begin
              // Bit boundary with no beat taken: stream ends, line level is held.
              state      <= ST_IDLE;
              s_ready    <= 1'b0;
              line_oe    <= 1'b0;
              busy_o     <= 1'b0;
              underrun_o <= enable;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dmc_encode.sv
// Self-checking bench for dmc_encode: randomized frames against a waveform-expansion model.
// Follows DMC_ENC_SCRAMBLE_EN so the model scrambles exactly when the design does.
module tb_dmc_encode;

  localparam int HP_W      = 8;
  localparam int PRE_UNITS = 3;

  logic            clk_i = 1'b0;
  logic            reset;
  logic            enable;
  logic [HP_W-1:0] HALF_PERIOD;
  logic            s_valid;
  logic            s_data;
  logic            s_sync;
  logic            s_ready;
  logic            line_o;
  logic            line_oe;
  logic            busy_o;
  logic            underrun_o;

  int n_tests = 0;
  int n_fail  = 0;

  bit model_level;
  int model_lfsr;
  bit beat_d[64];
  bit beat_s[64];
  bit exp_line[$];
  bit exp_rdy[$];

  dmc_encode #(.HP_W(HP_W), .PRE_UNITS(PRE_UNITS)) dut (
    .clk_i       (clk_i),
    .reset       (reset),
    .enable      (enable),
    .HALF_PERIOD (HALF_PERIOD),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_sync      (s_sync),
    .s_ready     (s_ready),
    .line_o      (line_o),
    .line_oe     (line_oe),
    .busy_o      (busy_o),
    .underrun_o  (underrun_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Bit actually put on the line for an accepted beat.
  function automatic bit model_enc(input bit d, input bit sync);
    bit key;
    if (sync) model_lfsr = 'h7F;
    key = bit'(((model_lfsr >> 6) ^ (model_lfsr >> 5)) & 1);
    model_lfsr = ((model_lfsr << 1) | int'(key)) & 'h7F;
`ifdef DMC_ENC_SCRAMBLE_EN
    return d ^ key;
`else
    return d;
`endif
  endfunction

  // Expand beats into the per-cycle line level and s_ready expected after acceptance.
  task automatic build(input int hp, input int n, input bit last_off);
    bit lv;
    bit e;
    lv = model_level;
    exp_line.delete();
    exp_rdy.delete();
    for (int i = 0; i < n; i++) begin
      e = model_enc(beat_d[i], beat_s[i]);
      if (beat_s[i]) begin
        for (int r = 0; r < 2; r++) begin
          lv = ~lv;
          repeat (PRE_UNITS * hp) begin exp_line.push_back(lv); exp_rdy.push_back(1'b0); end
        end
      end
      lv = ~lv;
      repeat (hp) begin exp_line.push_back(lv); exp_rdy.push_back(1'b0); end
      if (e) lv = ~lv;
      repeat (hp) begin exp_line.push_back(lv); exp_rdy.push_back(1'b0); end
      exp_rdy[exp_rdy.size() - 1] = 1'b1;
    end
    if (last_off) exp_rdy[exp_rdy.size() - 1] = 1'b0;
    model_level = lv;
  endtask

  task automatic wait_ready(input string tag);
    int k;
    k = 0;
    while (!s_ready && k < 100) begin step(); k++; end
    chk(tag, s_ready, 1);
  endtask

  task automatic run_frame(input int hp_req, input int n, input bit last_off);
    int hp;
    int idx;
    hp = (hp_req < 2) ? 2 : hp_req;
    build(hp, n, last_off);
    wait_ready("idle_ready");
    HALF_PERIOD = HP_W'(hp_req);
    s_valid = 1'b1;
    s_data  = beat_d[0];
    s_sync  = beat_s[0];
    step();
    idx = 1;
    for (int c = 0; c < exp_line.size(); c++) begin
      chk("line", line_o, exp_line[c]);
      chk("ready", s_ready, exp_rdy[c]);
      chk("oe", line_oe, 1);
      chk("busy", busy_o, 1);
      chk("urun_idle", underrun_o, 0);
      if (last_off && c == exp_line.size() - 2) enable = 1'b0;
      if (exp_rdy[c]) begin
        HALF_PERIOD = HP_W'(hp_req);
        if (idx < n) begin
          s_valid = 1'b1;
          s_data  = beat_d[idx];
          s_sync  = beat_s[idx];
          idx++;
        end else begin
          s_valid = 1'b0;
        end
      end else begin
        HALF_PERIOD = HP_W'($urandom_range(0, 255));
        s_valid     = 1'($urandom);
        s_data      = 1'($urandom);
        s_sync      = 1'($urandom);
      end
      step();
    end
    s_valid = 1'b0;
    chk("end_urun", underrun_o, last_off ? 0 : 1);
    chk("end_oe", line_oe, 0);
    chk("end_busy", busy_o, 0);
    chk("end_hold", line_o, model_level);
    chk("end_ready", s_ready, 0);
    step();
    chk("urun_pulse", underrun_o, 0);
    chk("idle_hold", line_o, model_level);
    enable = 1'b1;
  endtask

  initial begin
    int n;
    reset       = 1'b1;
    enable      = 1'b0;
    s_valid     = 1'b0;
    s_data      = 1'b0;
    s_sync      = 1'b0;
    HALF_PERIOD = HP_W'(4);
    model_level = 1'b0;
    model_lfsr  = 'h7F;
    repeat (3) step();
    chk("rst_line", line_o, 0);
    chk("rst_oe", line_oe, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_ready", s_ready, 0);
    chk("rst_urun", underrun_o, 0);

    reset = 1'b0;
    step();
    step();
    chk("dis_ready", s_ready, 0);
    chk("dis_line", line_o, 0);
    chk("dis_oe", line_oe, 0);
    chk("dis_busy", busy_o, 0);

    enable = 1'b1;
    step();
    chk("en_ready", s_ready, 1);
    chk("en_line", line_o, 0);
    chk("en_oe", line_oe, 0);

    // Single sync beat carrying a one, HP=4.
    beat_s[0] = 1'b1; beat_d[0] = 1'b1;
    run_frame(4, 1, 1'b0);

    // Sync stream 1,0,0,1 back to back.
    beat_s[0] = 1'b1; beat_d[0] = 1'b1;
    beat_s[1] = 1'b0; beat_d[1] = 1'b0;
    beat_s[2] = 1'b0; beat_d[2] = 1'b0;
    beat_s[3] = 1'b0; beat_d[3] = 1'b1;
    run_frame(4, 4, 1'b0);

    // Sync beat followed by seven zeros.
    for (int i = 0; i < 8; i++) begin beat_d[i] = 1'b0; beat_s[i] = (i == 0); end
    run_frame(3, 8, 1'b0);

    // Enable dropped at the final boundary, then half-period clamping.
    for (int i = 0; i < 4; i++) begin beat_d[i] = 1'($urandom); beat_s[i] = (i == 2); end
    run_frame(2, 3, 1'b1);
    run_frame(1, 4, 1'b0);
    run_frame(0, 2, 1'b0);

    // Asynchronous reset in the middle of a preamble.
    wait_ready("pre_ready");
    HALF_PERIOD = HP_W'(4);
    s_valid = 1'b1; s_sync = 1'b1; s_data = 1'b1;
    step();
    s_valid = 1'b0;
    repeat (5) step();
    chk("pre_busy", busy_o, 1);
    chk("pre_oe", line_oe, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_line", line_o, 0);
    chk("arst_oe", line_oe, 0);
    chk("arst_busy", busy_o, 0);
    chk("arst_ready", s_ready, 0);
    @(posedge clk_i);
    #1 reset = 1'b0;
    model_level = 1'b0;
    model_lfsr  = 'h7F;
    beat_s[0] = 1'b1; beat_d[0] = 1'b0;
    beat_s[1] = 1'b0; beat_d[1] = 1'b1;
    beat_s[2] = 1'b0; beat_d[2] = 1'b1;
    run_frame(4, 3, 1'b0);

    repeat (10) begin
      n = $urandom_range(1, 10);
      for (int i = 0; i < n; i++) begin
        beat_d[i] = 1'($urandom);
        beat_s[i] = (i == 0) ? 1'($urandom) : ($urandom_range(0, 4) == 0);
      end
      run_frame($urandom_range(0, 7), n, $urandom_range(0, 3) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
